// File: rtl/core_bus_sched.sv
// Single-outstanding bus scheduler for three requesters (data > dma > insn).
// Define CORE_BUS_STARVE_GUARD_EN to force an insn grant after STARVE_LIMIT data/dma grants.
module core_bus_sched #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] insn_addr,
    input  logic        insn_start,
    output logic        insn_ready,
    output logic [31:0] insn_data_rd,
    input  logic [29:0] data_addr,
    input  logic        data_start,
    input  logic        data_write,
    input  logic [31:0] data_data_wr,
    input  logic [3:0]  data_data_be,
    output logic        data_ready,
    output logic [31:0] data_data_rd,
    input  logic [29:0] dma_addr,
    input  logic        dma_start,
    input  logic        dma_write,
    input  logic [31:0] dma_data_wr,
    input  logic [3:0]  dma_data_be,
    output logic        dma_ready,
    output logic [31:0] dma_data_rd,
    output logic [29:0] bus_addr,
    output logic        bus_start,
    output logic        bus_write,
    output logic [31:0] bus_data_wr,
    output logic [3:0]  bus_data_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_data_rd,
    output logic        idle
);
    localparam logic [1:0] P_INSN = 2'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    // Requester index: 0 = data, 1 = dma, 2 = insn (insn is always a full-word read).
    logic [2:0]       w_start;
    logic [2:0][29:0] w_addr;
    logic [2:0]       w_write;
    logic [2:0][31:0] w_wdata;
    logic [2:0][3:0]  w_be;
    assign w_start = {insn_start, dma_start, data_start};
    assign w_addr  = {insn_addr, dma_addr, data_addr};
    assign w_write = {1'b0, dma_write, data_write};
    assign w_wdata = {32'h0, dma_data_wr, data_data_wr};
    assign w_be    = {4'hF, dma_data_be, data_data_be};

    logic [2:0]       r_pend;
    logic [2:0][29:0] r_slot_addr;
    logic [2:0]       r_slot_write;
    logic [2:0][31:0] r_slot_wdata;
    logic [2:0][3:0]  r_slot_be;
    logic [1:0]       r_win, w_win;
    logic             w_grant, w_done, w_force;
    logic [2:0]       r_ready;
    logic [2:0][31:0] r_data_rd;
    logic [29:0]      r_bus_addr, w_sel_addr;
    logic             r_bus_start, r_bus_write, w_sel_write;
    logic [31:0]      r_bus_wdata, w_sel_wdata;
    logic [3:0]       r_bus_be, w_sel_be;

    always_comb begin
        w_win = P_INSN;
        if (w_force)        w_win = P_INSN;
        else if (r_pend[0]) w_win = 2'd0;
        else if (r_pend[1]) w_win = 2'd1;
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_write = 1'b0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int p = 0; p < 3; p++) begin
            if (w_win == 2'(p)) begin
                w_sel_addr  = r_slot_addr[p];
                w_sel_write = r_slot_write[p];
                w_sel_wdata = r_slot_wdata[p];
                w_sel_be    = r_slot_be[p];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:  if (|r_pend) begin
                         w_grant     = 1'b1;
                         w_state_nxt = S_ISSUE;
                     end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus_ready) begin
                         w_done      = 1'b1;
                         w_state_nxt = S_IDLE;
                     end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= '0;
            r_slot_addr  <= '0;
            r_slot_write <= '0;
            r_slot_wdata <= '0;
            r_slot_be    <= '0;
            r_win        <= '0;
            r_ready      <= '0;
            r_data_rd    <= '0;
            r_bus_addr   <= '0;
            r_bus_start  <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_wdata  <= '0;
            r_bus_be     <= '0;
        end else begin
            r_bus_start <= w_grant;
            r_ready     <= '0;
            if (w_grant) begin
                r_win       <= w_win;
                r_bus_addr  <= w_sel_addr;
                r_bus_write <= w_sel_write;
                r_bus_wdata <= w_sel_wdata;
                r_bus_be    <= w_sel_be;
            end
            // The winner's slot frees on completion, so its next start is accepted the cycle ready shows.
            for (int p = 0; p < 3; p++) begin
                if (w_done && r_win == 2'(p)) begin
                    r_pend[p]    <= 1'b0;
                    r_ready[p]   <= 1'b1;
                    r_data_rd[p] <= bus_data_rd;
                end else if (w_start[p] && !r_pend[p]) begin
                    r_pend[p]       <= 1'b1;
                    r_slot_addr[p]  <= w_addr[p];
                    r_slot_write[p] <= w_write[p];
                    r_slot_wdata[p] <= w_wdata[p];
                    r_slot_be[p]    <= w_be[p];
                end
            end
        end
    end

`ifdef CORE_BUS_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] r_starve;

    always_ff @(posedge clk) begin
        if (rst || !r_pend[P_INSN]) r_starve <= '0;
        else if (w_grant)           r_starve <= (w_win == P_INSN) ? '0 : r_starve + 1'b1;
    end

    assign w_force = r_pend[P_INSN] && (r_starve == LIMIT);
`else
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT != 0);
    assign w_force        = 1'b0;
`endif

    assign bus_addr     = r_bus_addr;
    assign bus_start    = r_bus_start;
    assign bus_write    = r_bus_write;
    assign bus_data_wr  = r_bus_wdata;
    assign bus_data_be  = r_bus_be;
    assign data_ready   = r_ready[0];
    assign dma_ready    = r_ready[1];
    assign insn_ready   = r_ready[2];
    assign data_data_rd = r_data_rd[0];
    assign dma_data_rd  = r_data_rd[1];
    assign insn_data_rd = r_data_rd[2];
    assign idle         = (r_state == S_IDLE) && !(|r_pend);
endmodule

// File: tb/tb_core_bus_sched.sv
// Randomized bench for core_bus_sched against a transaction-timing reference model.
module tb_core_bus_sched;
    localparam int LIMIT = 8;
`ifdef CORE_BUS_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] insn_addr, data_addr, dma_addr, bus_addr;
    logic        insn_start, data_start, dma_start, bus_start;
    logic        insn_ready, data_ready, dma_ready, bus_ready, idle;
    logic [31:0] insn_data_rd, data_data_rd, dma_data_rd, bus_data_rd;
    logic        data_write, dma_write, bus_write;
    logic [31:0] data_data_wr, dma_data_wr, bus_data_wr;
    logic [3:0]  data_data_be, dma_data_be, bus_data_be;

    core_bus_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .insn_addr(insn_addr), .insn_start(insn_start), .insn_ready(insn_ready), .insn_data_rd(insn_data_rd),
        .data_addr(data_addr), .data_start(data_start), .data_write(data_write), .data_data_wr(data_data_wr),
        .data_data_be(data_data_be), .data_ready(data_ready), .data_data_rd(data_data_rd),
        .dma_addr(dma_addr), .dma_start(dma_start), .dma_write(dma_write), .dma_data_wr(dma_data_wr),
        .dma_data_be(dma_data_be), .dma_ready(dma_ready), .dma_data_rd(dma_data_rd),
        .bus_addr(bus_addr), .bus_start(bus_start), .bus_write(bus_write), .bus_data_wr(bus_data_wr),
        .bus_data_be(bus_data_be), .bus_ready(bus_ready), .bus_data_rd(bus_data_rd), .idle(idle)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending requests per port, one transaction in flight at a time.
    int          cyc = 0;
    bit          rst_prev = 1'b1;
    logic [2:0]  m_pend, m_exp_rdy;
    logic [29:0] m_addr [3];
    logic        m_wr [3];
    logic [31:0] m_wd [3];
    logic [3:0]  m_be [3];
    logic [31:0] m_drd [3];
    bit          m_busy;
    int          m_win, m_issue_cyc, m_starve;
    logic [29:0] m_baddr;
    logic        m_bwr;
    logic [31:0] m_bwd;
    logic [3:0]  m_bbe;

    int issued [3], done [3];
    int rdy_order[$], st_cyc_q[$], br_cyc_q[$];
    logic st_wr_q[$];
    logic [3:0] st_be_q[$];
    logic [29:0] last_st_addr;
    int last_rdy_cyc [3];
    int n_rdy_total = 0, n_st = 0, last_go_cyc = 0;

    bit slave_en = 1'b1;
    int slave_dly = 0;
    logic [31:0] slave_data = '0;

    task automatic monitor();
        logic [2:0]  rv, s, cap, clr;
        logic [31:0] drd [3];
        logic [29:0] ia [3];
        logic        iw [3];
        logic [31:0] iwd [3];
        logic [3:0]  ibe [3];
        int          w;
        forever begin
            @(negedge clk);
            rv = {insn_ready, dma_ready, data_ready};
            drd[0] = data_data_rd; drd[1] = dma_data_rd; drd[2] = insn_data_rd;
            if (rst_prev) begin
                chk("rst_bus_start", 64'(bus_start), 64'(0));
                chk("rst_bus_addr", 64'(bus_addr), 64'(0));
                chk("rst_bus_ctl", 64'({bus_write, bus_data_be}), 64'(0));
                chk("rst_bus_wd", 64'(bus_data_wr), 64'(0));
                chk("rst_ready", 64'(rv), 64'(0));
                for (int p = 0; p < 3; p++) chk("rst_data_rd", 64'(drd[p]), 64'(0));
                chk("rst_idle", 64'(idle), 64'(1));
                m_pend = '0; m_busy = 1'b0; m_starve = 0; m_exp_rdy = '0;
                for (int p = 0; p < 3; p++) m_drd[p] = '0;
            end else begin
                chk("one_ready", 64'($countones(rv) <= 1), 64'(1));
                chk("ready", 64'(rv), 64'(m_exp_rdy));
                for (int p = 0; p < 3; p++) chk("data_rd", 64'(drd[p]), 64'(m_drd[p]));
                chk("bus_start", 64'(bus_start), 64'(m_busy && cyc == m_issue_cyc));
                chk("idle", 64'(idle), 64'(m_pend == 3'b000 && !m_busy));
                if (m_busy && cyc >= m_issue_cyc) begin
                    chk("bus_addr", 64'(bus_addr), 64'(m_baddr));
                    chk("bus_ctl", 64'({bus_write, bus_data_be}), 64'({m_bwr, m_bbe}));
                    chk("bus_wd", 64'(bus_data_wr), 64'(m_bwd));
                end
            end
            for (int p = 0; p < 3; p++)
                if (rv[p]) begin
                    done[p]++; n_rdy_total++; rdy_order.push_back(p); last_rdy_cyc[p] = cyc;
                end
            if (bus_start) begin
                st_cyc_q.push_back(cyc); st_wr_q.push_back(bus_write); st_be_q.push_back(bus_data_be);
                last_st_addr = bus_addr; n_st++;
            end
            if (bus_ready) br_cyc_q.push_back(cyc);

            if (!rst) begin
                s = {insn_start, dma_start, data_start};
                ia[0] = data_addr; iw[0] = data_write; iwd[0] = data_data_wr; ibe[0] = data_data_be;
                ia[1] = dma_addr;  iw[1] = dma_write;  iwd[1] = dma_data_wr;  ibe[1] = dma_data_be;
                ia[2] = insn_addr; iw[2] = 1'b0;       iwd[2] = 32'h0;        ibe[2] = 4'hF;
                m_exp_rdy = '0; clr = '0; cap = '0;
                if (m_busy && cyc > m_issue_cyc && bus_ready) begin
                    m_exp_rdy[m_win] = 1'b1; m_drd[m_win] = bus_data_rd; clr[m_win] = 1'b1; m_busy = 1'b0;
                end else if (!m_busy && m_pend != 3'b000) begin
                    if (GUARD && m_pend[2] && m_starve == LIMIT) w = 2;
                    else if (m_pend[0]) w = 0;
                    else if (m_pend[1]) w = 1;
                    else w = 2;
                    m_win = w; m_busy = 1'b1; m_issue_cyc = cyc + 1;
                    m_baddr = m_addr[w]; m_bwr = m_wr[w]; m_bwd = m_wd[w]; m_bbe = m_be[w];
                    if (m_pend[2]) m_starve = (w == 2) ? 0 : m_starve + 1;
                end
                if (!m_pend[2]) m_starve = 0;
                for (int p = 0; p < 3; p++)
                    if (s[p]) begin
                        assert (!m_pend[p]) else $error("protocol violation: start on pending slot %0d", p);
                        if (!m_pend[p]) begin
                            cap[p] = 1'b1;
                            m_addr[p] = ia[p]; m_wr[p] = iw[p]; m_wd[p] = iwd[p]; m_be[p] = ibe[p];
                        end
                    end
                m_pend = (m_pend & ~clr) | cap;
            end
            rst_prev = rst;
            cyc++;
        end
    endtask

    task automatic slave();
        int d;
        forever begin
            @(negedge clk);
            if (slave_en && bus_start) begin
                d = (slave_dly != 0) ? slave_dly : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1 bus_ready = 1'b1;
                bus_data_rd = (slave_data != 0) ? slave_data : $urandom;
                @(posedge clk);
                #1 bus_ready = 1'b0;
            end
        end
    endtask

    task automatic go(input logic [2:0] m);
        @(posedge clk); #1;
        data_start = m[0]; dma_start = m[1]; insn_start = m[2];
        last_go_cyc = cyc;
        for (int p = 0; p < 3; p++) if (m[p]) issued[p]++;
        @(posedge clk); #1;
        data_start = 1'b0; dma_start = 1'b0; insn_start = 1'b0;
    endtask

    task automatic rand_fields();
        data_addr = 30'($urandom); data_write = 1'($urandom); data_data_wr = $urandom; data_data_be = 4'($urandom);
        dma_addr  = 30'($urandom); dma_write  = 1'($urandom); dma_data_wr  = $urandom; dma_data_be  = 4'($urandom);
        insn_addr = 30'($urandom);
    endtask

    task automatic wait_quiet(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (idle && issued[0] == done[0] && issued[1] == done[1] && issued[2] == done[2]) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    task automatic wait_bus_start(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus_start) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    initial begin
        int n_before, n_dd, dd0, rdy0, st0;
        bit seen;
        rst = 1'b1; bus_ready = 1'b0; bus_data_rd = '0;
        insn_start = 1'b0; data_start = 1'b0; dma_start = 1'b0;
        rand_fields();
        for (int p = 0; p < 3; p++) begin issued[p] = 0; done[p] = 0; end
        fork
            monitor();
            slave();
            begin
                #400000;
                $display("FAIL watchdog: time limit reached, got running expected finished");
                $fatal(1, "time limit");
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single insn read, bus answers 3 cycles after bus_start.
        slave_dly = 3; slave_data = 32'hE3A00001; insn_addr = 30'h100;
        st_cyc_q.delete(); br_cyc_q.delete();
        go(3'b100);
        wait_quiet("r027_quiet");
        chk("r027_insn_data", 64'(insn_data_rd), 64'h0E3A00001);
        chk("r027_bus_addr", 64'(last_st_addr), 64'h100);
        chk("r027_bus_write", 64'(st_wr_q[$]), 64'(0));
        chk("r027_latency", 64'(st_cyc_q[$] - last_go_cyc), 64'(2));
        chk("r027_ready_cyc", 64'(last_rdy_cyc[2] - br_cyc_q[$]), 64'(1));

        // Data write and insn read in the same cycle: data first.
        slave_dly = 0; slave_data = '0;
        data_addr = 30'h2A0; data_write = 1'b1; data_data_wr = 32'hCAFE0001; data_data_be = 4'h5; insn_addr = 30'h200;
        rdy_order.delete(); st_cyc_q.delete(); st_wr_q.delete(); st_be_q.delete(); br_cyc_q.delete();
        go(3'b101);
        wait_quiet("r028_quiet");
        chk("r028_count", 64'(rdy_order.size()), 64'(2));
        if (rdy_order.size() == 2 && st_cyc_q.size() == 2 && br_cyc_q.size() >= 1) begin
            chk("r028_first", 64'(rdy_order[0]), 64'(0));
            chk("r028_second", 64'(rdy_order[1]), 64'(2));
            chk("r028_write", 64'({st_wr_q[0], st_be_q[0]}), 64'({1'b1, 4'h5}));
            chk("r028_insn_gap", 64'(st_cyc_q[1] - br_cyc_q[0]), 64'(2));
        end

        // Restart data in the same cycle its ready shows.
        slave_en = 1'b0; data_write = 1'b0; data_addr = 30'h3001;
        go(3'b001);
        wait_bus_start("r031_first_start");
        @(posedge clk); #1 bus_ready = 1'b1; bus_data_rd = 32'h1234_5678;
        @(posedge clk); #1 bus_ready = 1'b0;
        data_start = 1'b1; data_addr = 30'h3002; issued[0]++;
        @(posedge clk); #1 data_start = 1'b0;
        wait_bus_start("r031_second_start");
        chk("r031_gap", 64'(st_cyc_q[$] - last_rdy_cyc[0]), 64'(2));
        chk("r031_addr", 64'(last_st_addr), 64'h3002);
        @(posedge clk); #1 bus_ready = 1'b1; bus_data_rd = 32'h9ABC_DEF0;
        @(posedge clk); #1 bus_ready = 1'b0;
        wait_quiet("r031_quiet");

        // Reset during WAIT, stale bus_ready afterwards.
        data_write = 1'b1; data_addr = 30'h4444;
        go(3'b001);
        wait_bus_start("r030_start");
        rdy0 = n_rdy_total; st0 = n_st;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 bus_ready = 1'b1; bus_data_rd = 32'hDEAD_BEEF;
        @(posedge clk); #1 bus_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("r030_no_ready", 64'(n_rdy_total - rdy0), 64'(0));
        chk("r030_no_start", 64'(n_st - st0), 64'(0));
        chk("r030_idle", 64'(idle), 64'(1));
        chk("r030_data_rd", 64'(data_data_rd), 64'(0));
        for (int p = 0; p < 3; p++) issued[p] = done[p];
        slave_en = 1'b1;

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            rand_fields();
            data_start = (issued[0] == done[0]) && ($urandom_range(0, 3) == 0);
            dma_start  = (issued[1] == done[1]) && ($urandom_range(0, 3) == 0);
            insn_start = (issued[2] == done[2]) && ($urandom_range(0, 3) == 0);
            if (data_start) issued[0]++;
            if (dma_start)  issued[1]++;
            if (insn_start) issued[2]++;
        end
        @(posedge clk); #1 data_start = 1'b0; dma_start = 1'b0; insn_start = 1'b0;
        wait_quiet("rand_quiet");

        // Starvation: data and dma kept pending while insn waits.
        rdy_order.delete();
        dd0 = done[0] + done[1];
        @(posedge clk); #1;
        rand_fields();
        data_start = 1'b1; dma_start = 1'b1; insn_start = 1'b1;
        issued[0]++; issued[1]++; issued[2]++;
        for (int i = 0; i < 3000 && (done[0] + done[1] - dd0) < 20; i++) begin
            @(posedge clk); #1;
            rand_fields();
            insn_start = 1'b0;
            data_start = (issued[0] == done[0]);
            dma_start  = (issued[1] == done[1]);
            if (data_start) issued[0]++;
            if (dma_start)  issued[1]++;
        end
        @(posedge clk); #1 data_start = 1'b0; dma_start = 1'b0;
        wait_quiet("starve_quiet");
        n_before = 0; n_dd = 0; seen = 1'b0;
        foreach (rdy_order[i]) begin
            if (rdy_order[i] == 2) seen = 1'b1;
            else begin
                n_dd++;
                if (!seen) n_before++;
            end
        end
        chk("starve_insn_seen", 64'(seen), 64'(1));
        chk("starve_dd_total", 64'(n_dd >= 20), 64'(1));
        chk("starve_grants_before_insn", 64'(n_before), 64'(GUARD ? LIMIT : n_dd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/core_bus_sched.md
CORE_BUS_SCHED -- requirements
Module: core_bus_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: the maximum number of consecutive data/dma grants while an insn request waits (guard enabled only).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports insn_addr  input  30  and insn_start  input  1  for the read-only instruction requester.
REQ-005 SHALL have ports insn_ready  output  1  and insn_data_rd  output  32  for instruction completion.
REQ-006 SHALL have, for each of data_ and dma_: addr input 30, start input 1, write input 1, data_wr input 32, data_be input 4, ready output 1, data_rd output 32.
REQ-007 SHALL have bus_addr output 30, bus_start output 1, bus_write output 1, bus_data_wr output 32, bus_data_be output 4.
REQ-008 SHALL have bus_ready input 1, bus_data_rd input 32, and idle output 1 (no pending request and no transaction in flight).

Function
REQ-009 SHALL capture a port's addr/write/data_wr/data_be into its pending slot on any cycle its start is high; insn captures write=0, be=4'hF.
REQ-010 SHALL ignore start on a port whose slot is already pending; this is a protocol violation, flagged by a bench assertion.
REQ-011 SHALL use FSM states IDLE -> ISSUE -> WAIT -> IDLE.
REQ-012 IDLE: if any slot is pending, SHALL select a winner, load the bus registers from its slot and go to ISSUE; otherwise remain in IDLE.
REQ-013 ISSUE: SHALL drive bus_start=1 for exactly one cycle with registered bus_* fields, then go to WAIT.
REQ-014 WAIT: SHALL hold bus_addr/write/data_wr/data_be stable until bus_ready, then go to IDLE.
REQ-015 SHALL ignore bus_ready in IDLE and ISSUE.
REQ-016 On bus_ready in cycle n, SHALL pulse the winner's ready for one cycle at n+1, with data_rd registered from bus_data_rd.
REQ-017 SHALL hold each port's data_rd until that port's next completion; writes also update data_rd.
REQ-018 SHALL clear the winner's slot at n+1, so a start in that same cycle is captured as a new request.
REQ-019 SHALL give minimum latency start(t) -> bus_start(t+2); bus_start of the next transaction SHALL occur no earlier than n+2.
REQ-020 Arbitration priority SHALL be data > dma > insn.
REQ-021 SHALL never assert two ready outputs in the same cycle.

Reset
REQ-022 While rst=1: state=IDLE, all slots cleared, bus_start=0, bus_write=0, bus_addr=0, bus_data_wr=0, bus_data_be=0, all ready=0, all data_rd=0, idle=1, starvation counter=0.
REQ-023 Reset mid-transaction SHALL abandon the transaction: no ready pulse, and a later stale bus_ready SHALL be ignored.

Configuration
REQ-024 Macro CORE_BUS_STARVE_GUARD_EN defined: a counter SHALL increment on each data/dma grant while insn is pending, and clear on an insn grant or when insn is not pending.
REQ-025 When the counter equals STARVE_LIMIT, insn SHALL win the next arbitration regardless of other slots.
REQ-026 Macro CORE_BUS_STARVE_GUARD_EN undefined: the counter SHALL be absent and priority strictly fixed per REQ-020.

Verification
REQ-027 insn_start with addr 30'h100; bus_ready 3 cycles after bus_start with data 32'hE3A00001 -> bus_addr=30'h100, bus_write=0, insn_ready one cycle later, insn_data_rd=32'hE3A00001.
REQ-028 data write and insn read started in the same cycle -> data issued first (bus_write=1, be as given); insn bus_start exactly 2 cycles after data_ready-causing bus_ready.
REQ-029 data and dma kept continuously pending for 20 transactions with insn pending, guard on, STARVE_LIMIT=8 -> insn granted after the 8th data/dma grant. Guard off -> insn never granted until data/dma stop.
REQ-030 rst asserted during WAIT, bus_ready pulsed 2 cycles after reset release -> no ready output, idle=1, bus_start stays 0.
REQ-031 data_start re-asserted in the same cycle as data_ready -> second transaction issued, bus_start at that cycle +2.
REQ-032 Throughout all scenarios -> at most one ready output high per cycle, and bus_* stable during WAIT.
